uart_step_regfile: RTL and testbench

- Parametrised successor to the UART-driven single-step register file. It accepts one instruction per step via a valid/ready handshake from the UART receiver, and generates a fixed-length burst of clk_proc cycles. It presents the instruction on the first processor cycle and NOP afterwards, and hosts the processor register file.
- After each step it offers a frozen regfile snapshot plus a dirty-register mask to the UART transmitter, so only changed registers need to be sent.

---
 rtl/uart_step_regfile_if.sv | 23 ++
 rtl/uart_step_regfile.sv | 156 +++++++++++++++
 tb/tb_uart_step_regfile.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_step_regfile_if.sv
// rtl/uart_step_regfile_if.sv - instruction and regfile-dump handshakes between the UART side and the step block
interface uart_step_regfile_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  logic                  inst_valid;
  logic                  inst_ready;
  logic [XLEN-1:0]       inst_data;
  logic                  dump_valid;
  logic                  dump_ready;
  logic [NREGS*XLEN-1:0] dump_data;
  logic [NREGS-1:0]      dump_mask;

  modport master (
    output inst_valid, inst_data, dump_ready,
    input  inst_ready, dump_valid, dump_data, dump_mask
  );

  modport slave (
    input  inst_valid, inst_data, dump_ready,
    output inst_ready, dump_valid, dump_data, dump_mask
  );
endinterface

// File: rtl/uart_step_regfile.sv
// rtl/uart_step_regfile.sv - single-step processor clock burst generator with hosted regfile and dirty-mask dump
module uart_step_regfile #(
  parameter int              XLEN        = 32,
  parameter int              NREGS       = 32,
  parameter int              AW          = 5,
  parameter int              STEP_CYCLES = 5,
  parameter int              HALF_PERIOD = 1,
  parameter logic [XLEN-1:0] NOP         = XLEN'(32'h00000013)
) (
  input  logic                  clk12,
  input  logic                  rst,
  uart_step_regfile_if.slave    uart,
  output logic                  clk_proc,
  output logic [XLEN-1:0]       inst_out,
  output logic                  busy,
  input  logic                  rf_we,
  input  logic [AW-1:0]         rf_waddr,
  input  logic [XLEN-1:0]       rf_wdata,
  input  logic [AW-1:0]         rf_raddr0,
  input  logic [AW-1:0]         rf_raddr1,
  output logic [XLEN-1:0]       rf_rdata0,
  output logic [XLEN-1:0]       rf_rdata1,
  output logic                  overrun,
  input  logic                  overrun_clr
);
  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DUMP} state_t;

  localparam int PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] LAST_CYCLE = CW'(STEP_CYCLES - 1);

  state_t          state;
  logic [PW-1:0]   phase_cnt;
  logic [CW-1:0]   cycle_cnt;
  logic [XLEN-1:0] inst_reg;
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] dirty;
  logic            proc_rise;
  logic            wr_en;
  logic            dump_fire;

  assign proc_rise = (state == S_LOW) && (phase_cnt == LAST_PHASE);
  assign wr_en     = proc_rise && rf_we && (rf_waddr != '0) && (32'(rf_waddr) < NREGS);
  assign dump_fire = uart.dump_valid && uart.dump_ready;

  always_ff @(posedge clk12 or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      clk_proc        <= 1'b1;
      uart.inst_ready <= 1'b1;
      busy            <= 1'b0;
      uart.dump_valid <= 1'b0;
      inst_reg        <= '0;
      phase_cnt       <= '0;
      cycle_cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (uart.inst_valid) begin
            inst_reg        <= uart.inst_data;
            cycle_cnt       <= '0;
            phase_cnt       <= '0;
            clk_proc        <= 1'b0;
            uart.inst_ready <= 1'b0;
            busy            <= 1'b1;
            state           <= S_LOW;
          end
        end
        S_LOW: begin
          if (phase_cnt == LAST_PHASE) begin
            phase_cnt <= '0;
            clk_proc  <= 1'b1;
            state     <= S_HIGH;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        S_HIGH: begin
          if (phase_cnt == LAST_PHASE) begin
            phase_cnt <= '0;
            if (cycle_cnt == LAST_CYCLE) begin
              uart.dump_valid <= 1'b1;
              state           <= S_DUMP;
            end else begin
              cycle_cnt <= cycle_cnt + 1'b1;
              clk_proc  <= 1'b0;
              state     <= S_LOW;
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        S_DUMP: begin
          if (uart.dump_ready) begin
            uart.dump_valid <= 1'b0;
            uart.inst_ready <= 1'b1;
            busy            <= 1'b0;
            state           <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The step instruction is only visible during the first processor cycle.
  always_comb begin
    inst_out = NOP;
    if ((state == S_LOW || state == S_HIGH) && cycle_cnt == '0)
      inst_out = inst_reg;
  end

  function automatic logic [XLEN-1:0] rd(input logic [AW-1:0] a);
    if (a != '0 && 32'(a) < NREGS)
      return regs[a[IW-1:0]];
    return '0;
  endfunction

  // Reads sample pre-write contents; regs[0] is never written so it stays zero.
  always_ff @(posedge clk12 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
      dirty     <= '0;
      rf_rdata0 <= '0;
      rf_rdata1 <= '0;
    end else begin
      if (dump_fire)
        dirty <= '0;
      if (proc_rise) begin
        rf_rdata0 <= rd(rf_raddr0);
        rf_rdata1 <= rd(rf_raddr1);
        if (wr_en) begin
          regs[rf_waddr[IW-1:0]]  <= rf_wdata;
          dirty[rf_waddr[IW-1:0]] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk12 or posedge rst) begin
    if (rst)
      overrun <= 1'b0;
    else if (uart.inst_valid && !uart.inst_ready)
      overrun <= 1'b1;
    else if (overrun_clr)
      overrun <= 1'b0;
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_dump
    assign uart.dump_data[g*XLEN +: XLEN] = regs[g];
  end
  assign uart.dump_mask = dirty;
endmodule

// File: tb/tb_uart_step_regfile.sv
// tb/tb_uart_step_regfile.sv - directed self-checking bench for uart_step_regfile
module tb_uart_step_regfile;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk12 = 1'b0;
  logic rst;
  always #5 clk12 = ~clk12;

  uart_step_regfile_if #(.XLEN(32), .NREGS(32)) if_a ();
  uart_step_regfile_if #(.XLEN(32), .NREGS(32)) if_b ();

  logic        clk_proc_a, busy_a, rf_we_a, overrun_a, overrun_clr_a;
  logic [31:0] inst_out_a, rf_wdata_a, rf_rdata0_a, rf_rdata1_a;
  logic [4:0]  rf_waddr_a, rf_raddr0_a, rf_raddr1_a;
  logic        clk_proc_b, busy_b, rf_we_b, overrun_b, overrun_clr_b;
  logic [31:0] inst_out_b, rf_wdata_b, rf_rdata0_b, rf_rdata1_b;
  logic [4:0]  rf_waddr_b, rf_raddr0_b, rf_raddr1_b;

  uart_step_regfile dut_a (
    .clk12(clk12), .rst(rst), .uart(if_a), .clk_proc(clk_proc_a), .inst_out(inst_out_a),
    .busy(busy_a), .rf_we(rf_we_a), .rf_waddr(rf_waddr_a), .rf_wdata(rf_wdata_a),
    .rf_raddr0(rf_raddr0_a), .rf_raddr1(rf_raddr1_a), .rf_rdata0(rf_rdata0_a),
    .rf_rdata1(rf_rdata1_a), .overrun(overrun_a), .overrun_clr(overrun_clr_a)
  );

  uart_step_regfile #(.STEP_CYCLES(2), .HALF_PERIOD(3)) dut_b (
    .clk12(clk12), .rst(rst), .uart(if_b), .clk_proc(clk_proc_b), .inst_out(inst_out_b),
    .busy(busy_b), .rf_we(rf_we_b), .rf_waddr(rf_waddr_b), .rf_wdata(rf_wdata_b),
    .rf_raddr0(rf_raddr0_b), .rf_raddr1(rf_raddr1_b), .rf_rdata0(rf_rdata0_b),
    .rf_rdata1(rf_rdata1_b), .overrun(overrun_b), .overrun_clr(overrun_clr_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk12);
    @(negedge clk12);
  endtask

  task automatic run_step_a(input logic [31:0] inst, input logic we, input logic [4:0] waddr,
                            input logic [31:0] wdata, output int edges, output int rises,
                            output int hits, output logic [31:0] rd_first, output logic [31:0] rd_second);
    logic prev;
    if_a.inst_valid = 1'b1;
    if_a.inst_data  = inst;
    rf_we_a    = we;
    rf_waddr_a = waddr;
    rf_wdata_a = wdata;
    tick();
    if_a.inst_valid = 1'b0;
    check_eq("accept_ready_low", {63'd0, if_a.inst_ready}, 64'd0);
    edges = 0; rises = 0; hits = 0; rd_first = '0; rd_second = '0;
    prev = clk_proc_a;
    while (!if_a.dump_valid && edges < 40) begin
      if (inst_out_a == inst) hits++;
      tick();
      edges++;
      if (!prev && clk_proc_a) begin
        rises++;
        if (rises == 1) begin
          rd_first = rf_rdata0_a;
          rf_we_a  = 1'b0;
        end else if (rises == 2) begin
          rd_second = rf_rdata0_a;
        end
      end
      prev = clk_proc_a;
    end
  endtask

  task automatic finish_dump_a;
    if_a.dump_ready = 1'b1;
    tick();
    if_a.dump_ready = 1'b0;
    check_eq("dump_release_valid", {63'd0, if_a.dump_valid}, 64'd0);
    check_eq("dump_release_ready", {63'd0, if_a.inst_ready}, 64'd1);
  endtask

  initial begin
    int edges, rises, hits, lo, hi;
    logic [31:0] rd1, rd2;
    logic seq [64];

    rst = 1'b1;
    if_a.inst_valid = 0; if_a.inst_data = 0; if_a.dump_ready = 0;
    if_b.inst_valid = 0; if_b.inst_data = 0; if_b.dump_ready = 0;
    rf_we_a = 0; rf_waddr_a = 0; rf_wdata_a = 0; rf_raddr0_a = 0; rf_raddr1_a = 0; overrun_clr_a = 0;
    rf_we_b = 0; rf_waddr_b = 0; rf_wdata_b = 0; rf_raddr0_b = 0; rf_raddr1_b = 0; overrun_clr_b = 0;
    tick(); tick();
    check_eq("rst_inst_ready", {63'd0, if_a.inst_ready}, 64'd1);
    check_eq("rst_busy", {63'd0, busy_a}, 64'd0);
    check_eq("rst_clk_proc", {63'd0, clk_proc_a}, 64'd1);
    check_eq("rst_dump_valid", {63'd0, if_a.dump_valid}, 64'd0);
    check_eq("rst_overrun", {63'd0, overrun_a}, 64'd0);
    check_eq("rst_inst_out", {32'd0, inst_out_a}, {32'd0, NOP});
    check_eq("rst_dump_mask", {32'd0, if_a.dump_mask}, 64'd0);
    rst = 1'b0;
    tick();

    // HALF_PERIOD=3, STEP_CYCLES=2 instance
    if_b.inst_valid = 1'b1;
    if_b.inst_data  = 32'h00100113;
    tick();
    if_b.inst_valid = 1'b0;
    edges = 0;
    while (!if_b.dump_valid && edges < 60) begin
      seq[edges] = clk_proc_b;
      tick();
      edges++;
    end
    lo = 0; hi = 0;
    while (lo < edges && seq[lo] == 1'b0) lo++;
    while (lo + hi < edges && seq[lo+hi] == 1'b1) hi++;
    check_eq("b_dump_latency", 64'(edges), 64'd12);
    check_eq("b_low_run", 64'(lo), 64'd3);
    check_eq("b_high_run", 64'(hi), 64'd3);
    if_b.dump_ready = 1'b1;
    tick();
    if_b.dump_ready = 1'b0;
    check_eq("b_dump_release", {63'd0, if_b.dump_valid}, 64'd0);

    // step 1: write x1=5 on the first processor rise
    run_step_a(32'h00500093, 1'b1, 5'd1, 32'd5, edges, rises, hits, rd1, rd2);
    check_eq("s1_dump_latency", 64'(edges), 64'd10);
    check_eq("s1_proc_rises", 64'(rises), 64'd5);
    check_eq("s1_inst_cycles", 64'(hits), 64'd2);
    check_eq("s1_x1", {32'd0, if_a.dump_data[63:32]}, 64'd5);
    check_eq("s1_mask", {32'd0, if_a.dump_mask}, 64'h2);
    for (int i = 0; i < 20; i++) tick();
    check_eq("hold_dump_valid", {63'd0, if_a.dump_valid}, 64'd1);
    check_eq("hold_clk_proc", {63'd0, clk_proc_a}, 64'd1);
    check_eq("hold_busy", {63'd0, busy_a}, 64'd1);
    check_eq("hold_inst_out", {32'd0, inst_out_a}, {32'd0, NOP});
    finish_dump_a();

    // step 2: write to x0 is dropped, mask stays empty
    rf_raddr0_a = 5'd0;
    rf_raddr1_a = 5'd1;
    run_step_a(32'h00000013, 1'b1, 5'd0, 32'hFFFFFFFF, edges, rises, hits, rd1, rd2);
    check_eq("s2_mask", {32'd0, if_a.dump_mask}, 64'd0);
    check_eq("s2_x0", {32'd0, if_a.dump_data[31:0]}, 64'd0);
    check_eq("s2_rdata0_x0", {32'd0, rf_rdata0_a}, 64'd0);
    check_eq("s2_rdata1_x1", {32'd0, rf_rdata1_a}, 64'd5);
    finish_dump_a();

    // step 3: x3=7
    run_step_a(32'h00700193, 1'b1, 5'd3, 32'd7, edges, rises, hits, rd1, rd2);
    check_eq("s3_mask", {32'd0, if_a.dump_mask}, 64'h8);
    check_eq("s3_x3", {32'd0, if_a.dump_data[127:96]}, 64'd7);
    finish_dump_a();

    // step 4: read-before-write on x3
    rf_raddr0_a = 5'd3;
    run_step_a(32'h00900193, 1'b1, 5'd3, 32'd9, edges, rises, hits, rd1, rd2);
    check_eq("s4_rbw_old", {32'd0, rd1}, 64'd7);
    check_eq("s4_rbw_new", {32'd0, rd2}, 64'd9);
    check_eq("s4_mask", {32'd0, if_a.dump_mask}, 64'h8);
    check_eq("s4_x1_kept", {32'd0, if_a.dump_data[63:32]}, 64'd5);
    finish_dump_a();

    // overrun while busy
    if_a.inst_valid = 1'b1;
    if_a.inst_data  = 32'h00000113;
    tick();
    if_a.inst_valid = 1'b0;
    tick();
    if_a.inst_valid = 1'b1;
    if_a.inst_data  = 32'hDEADBEEF;
    tick();
    check_eq("ovr_set", {63'd0, overrun_a}, 64'd1);
    check_eq("ovr_not_accepted", {32'd0, inst_out_a}, {32'd0, NOP});
    overrun_clr_a = 1'b1;
    tick();
    check_eq("ovr_set_wins", {63'd0, overrun_a}, 64'd1);
    if_a.inst_valid = 1'b0;
    tick();
    check_eq("ovr_clear", {63'd0, overrun_a}, 64'd0);
    overrun_clr_a = 1'b0;
    edges = 0;
    while (!if_a.dump_valid && edges < 40) begin
      tick();
      edges++;
    end
    check_eq("ovr_step_dump", {63'd0, if_a.dump_valid}, 64'd1);
    finish_dump_a();

    // asynchronous reset during LOW
    if_a.inst_valid = 1'b1;
    if_a.inst_data  = 32'h00500093;
    tick();
    if_a.inst_valid = 1'b0;
    check_eq("pre_rst_clk_low", {63'd0, clk_proc_a}, 64'd0);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_clk_proc", {63'd0, clk_proc_a}, 64'd1);
    check_eq("arst_dump_valid", {63'd0, if_a.dump_valid}, 64'd0);
    check_eq("arst_busy", {63'd0, busy_a}, 64'd0);
    check_eq("arst_rdata0", {32'd0, rf_rdata0_a}, 64'd0);
    check_eq("arst_x1", {32'd0, if_a.dump_data[63:32]}, 64'd0);
    check_eq("arst_x3", {32'd0, if_a.dump_data[127:96]}, 64'd0);
    check_eq("arst_inst_out", {32'd0, inst_out_a}, {32'd0, NOP});
    tick();
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
